// File: rtl/riscv_axi_pkg.sv
// Shared AXI-lite constants and arbiter types for the riscv core memory port.
package riscv_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_INSTR  = 3'b100;
    localparam logic [2:0] PROT_DATA   = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WRESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational two-way round-robin selector: req[0] = I, req[1] = D.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last_d,
    output logic       gnt_valid,
    output logic       gnt_d
);

    // On a tie grant whoever was not granted last; a lone requester wins outright.
    always_comb begin
        gnt_valid = |req;
        gnt_d     = 1'b0;
        if (req[0] && req[1]) begin
            gnt_d = ~last_d;
        end else begin
            gnt_d = req[1];
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI-lite memory port between instruction fetch (I) and the LSU (D),
// one transaction outstanding at a time.
module axi_lite_arbiter
    import riscv_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_arvalid,
    output logic                i_arready,
    input  logic [ADDR_W-1:0]   i_araddress,
    input  logic [2:0]          i_arprot,
    output logic                i_rvalid,
    input  logic                i_rready,
    output logic [DATA_W-1:0]   i_rdata,
    output logic [1:0]          i_rresp,

    input  logic                d_arvalid,
    output logic                d_arready,
    input  logic [ADDR_W-1:0]   d_araddress,
    input  logic [2:0]          d_arprot,
    output logic                d_rvalid,
    input  logic                d_rready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [1:0]          d_rresp,
    input  logic                d_awvalid,
    output logic                d_awready,
    input  logic [ADDR_W-1:0]   d_awaddress,
    input  logic [2:0]          d_awprot,
    input  logic                d_wvalid,
    output logic                d_wready,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_bvalid,
    input  logic                d_bready,
    output logic [1:0]          d_bresp,

    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddress,
    output logic [2:0]          arprot,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddress,
    output logic [2:0]          awprot,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp
);

    arb_state_t            state_q, state_d;
    arb_owner_t            owner_q, owner_d;
    arb_owner_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2:0]            prot_q, prot_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic                  aw_pend_q, aw_pend_d;
    logic                  w_pend_q, w_pend_d;

    logic                  d_wr_req;
    logic                  pick_valid;
    logic                  pick_d;
    logic                  aw_done;
    logic                  w_done;

    assign d_wr_req = d_awvalid && d_wvalid;

    rr_pick u_rr_pick (
        .req       ({d_wr_req || d_arvalid, i_arvalid}),
        .last_d    (last_grant_q == OWN_D),
        .gnt_valid (pick_valid),
        .gnt_d     (pick_d)
    );

    assign aw_done = !aw_pend_q || awready;
    assign w_done  = !w_pend_q  || wready;

    // Next-state, payload capture and requester readys; readys are held off while in reset.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        prot_d       = prot_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_pend_d    = aw_pend_q;
        w_pend_d     = w_pend_q;
        i_arready    = 1'b0;
        d_arready    = 1'b0;
        d_awready    = 1'b0;
        d_wready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reset && pick_valid) begin
                    if (!pick_d) begin
                        i_arready = 1'b1;
                        owner_d   = OWN_I;
                        addr_d    = i_araddress;
                        prot_d    = i_arprot;
                        state_d   = ST_RADDR;
                    end else if (d_wr_req) begin
                        d_awready = 1'b1;
                        d_wready  = 1'b1;
                        owner_d   = OWN_D;
                        addr_d    = d_awaddress;
                        prot_d    = d_awprot;
                        wdata_d   = d_wdata;
                        wstrb_d   = d_wstrb;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = ST_WADDR;
                    end else begin
                        d_arready = 1'b1;
                        owner_d   = OWN_D;
                        addr_d    = d_araddress;
                        prot_d    = d_arprot;
                        state_d   = ST_RADDR;
                    end
                end
            end
            ST_RADDR: begin
                if (arready) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (rvalid && rready) begin
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                end
            end
            ST_WADDR: begin
                if (awready) begin
                    aw_pend_d = 1'b0;
                end
                if (wready) begin
                    w_pend_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (bvalid && d_bready) begin
                    state_d      = ST_IDLE;
                    last_grant_d = OWN_D;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // External valids from state; responses pass straight through to the owner only.
    always_comb begin
        arvalid  = (state_q == ST_RADDR);
        awvalid  = (state_q == ST_WADDR) && aw_pend_q;
        wvalid   = (state_q == ST_WADDR) && w_pend_q;
        rready   = 1'b0;
        bready   = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        i_rresp  = '0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_rresp  = '0;
        d_bvalid = 1'b0;
        d_bresp  = '0;

        if (state_q == ST_RDATA) begin
            if (owner_q == OWN_I) begin
                rready   = i_rready;
                i_rvalid = rvalid;
                i_rdata  = rdata;
                i_rresp  = rresp;
            end else begin
                rready   = d_rready;
                d_rvalid = rvalid;
                d_rdata  = rdata;
                d_rresp  = rresp;
            end
        end

        if (state_q == ST_WRESP) begin
            bready   = d_bready;
            d_bvalid = bvalid;
            d_bresp  = bresp;
        end
    end

    assign araddress = addr_q;
    assign arprot    = prot_q;
    assign awaddress = addr_q;
    assign awprot    = prot_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_D;
            addr_q       <= '0;
            prot_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            prot_q       <= prot_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_pend_q    <= aw_pend_d;
            w_pend_q     <= w_pend_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Randomized self-checking bench for axi_lite_arbiter with a transaction-level model.
module tb_axi_lite_arbiter;
    import riscv_axi_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_arvalid, i_arready, i_rvalid, i_rready;
    logic [31:0] i_araddress, i_rdata;
    logic [2:0]  i_arprot;
    logic [1:0]  i_rresp;
    logic        d_arvalid, d_arready, d_rvalid, d_rready;
    logic [31:0] d_araddress, d_rdata, d_awaddress, d_wdata;
    logic [2:0]  d_arprot, d_awprot;
    logic [1:0]  d_rresp, d_bresp;
    logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
    logic [3:0]  d_wstrb;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddress, rdata, awaddress, wdata;
    logic [2:0]  arprot, awprot;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddress(i_araddress), .i_arprot(i_arprot),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
        .d_arvalid(d_arvalid), .d_arready(d_arready), .d_araddress(d_araddress), .d_arprot(d_arprot),
        .d_rvalid(d_rvalid), .d_rready(d_rready), .d_rdata(d_rdata), .d_rresp(d_rresp),
        .d_awvalid(d_awvalid), .d_awready(d_awready), .d_awaddress(d_awaddress), .d_awprot(d_awprot),
        .d_wvalid(d_wvalid), .d_wready(d_wready), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_bvalid(d_bvalid), .d_bready(d_bready), .d_bresp(d_bresp),
        .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state: kinds are 0 = I read, 1 = D read, 2 = D write.
    int          exp_q[$];
    int          model_last;          // 0 = I, 1 = D
    int          cur_kind;
    int          last_hs;
    bit          inflight;
    bit          i_pend, dr_pend, dw_pend;
    logic [31:0] i_addr, dr_addr, dw_addr, dw_data;
    logic [3:0]  dw_strb;

    // Slave model state.
    bit          s_rd, s_aw_done, s_w_done, s_b;
    int          s_rdelay, s_bdelay;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;

    // Service order for a set of simultaneous requests held until granted.
    task automatic build_expect(input bit ri, input bit rdr, input bit rdw);
        bit pi, pr, pw, take_i;
        pi = ri; pr = rdr; pw = rdw;
        while (pi || pr || pw) begin
            if (pi && (pr || pw)) take_i = (model_last == 1);
            else                  take_i = pi;
            if (take_i) begin
                exp_q.push_back(0); pi = 0; model_last = 0;
            end else if (pw) begin
                exp_q.push_back(2); pw = 0; model_last = 1;
            end else begin
                exp_q.push_back(1); pr = 0; model_last = 1;
            end
        end
    endtask

    task automatic note_grant(input int kind);
        check_val("grant_order", kind, (exp_q.size() != 0) ? exp_q[0] : 99);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        cur_kind = kind;
        inflight = 1;
        last_hs  = kind;
        case (kind)
            0:       i_pend  = 0;
            1:       dr_pend = 0;
            default: dw_pend = 0;
        endcase
    endtask

    task automatic clear_slave();
        s_rd = 0; s_aw_done = 0; s_w_done = 0; s_b = 0;
        s_rdelay = 0; s_bdelay = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
    endtask

    task automatic run_round(input bit ri, input bit rdr, input bit rdw,
                             input logic [31:0] ia, input logic [31:0] dra,
                             input logic [31:0] dwa, input logic [31:0] dwd,
                             input logic [3:0] dws);
        int cyc;
        int n_hs;
        logic [31:0] exp_addr;
        cyc = 0;
        i_pend = ri; dr_pend = rdr; dw_pend = rdw;
        i_addr = ia; dr_addr = dra; dw_addr = dwa; dw_data = dwd; dw_strb = dws;
        last_hs = -1;
        inflight = 0;
        build_expect(ri, rdr, rdw);
        while ((exp_q.size() != 0 || inflight) && cyc < 200) begin
            @(negedge clk);
            i_arvalid = i_pend; i_araddress = i_addr; i_arprot = PROT_INSTR;
            d_arvalid = dr_pend; d_araddress = dr_addr; d_arprot = PROT_DATA;
            d_awvalid = dw_pend; d_awaddress = dw_addr; d_awprot = PROT_DATA;
            d_wvalid = dw_pend; d_wdata = dw_data; d_wstrb = dw_strb;
            i_rready = ($urandom_range(0, 3) != 0);
            d_rready = ($urandom_range(0, 3) != 0);
            d_bready = ($urandom_range(0, 3) != 0);
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            if (s_rd && s_rdelay != 0) begin s_rdelay--; rvalid = 0; end
            else rvalid = s_rd;
            rdata = s_rdata; rresp = s_rresp;
            if (s_b && s_bdelay != 0) begin s_bdelay--; bvalid = 0; end
            else bvalid = s_b;
            bresp = s_bresp;
            #1;
            if (last_hs == 0 || last_hs == 1)
                check_val("ar_latency", {arvalid, awvalid, wvalid}, 3'b100);
            else if (last_hs == 2)
                check_val("aw_latency", {arvalid, awvalid, wvalid}, 3'b011);
            last_hs = -1;
            if (arvalid || awvalid)
                check_val("ar_aw_excl", arvalid && awvalid, 1'b0);
            if (s_rd || s_b)
                check_val("no_req_while_resp", {arvalid, awvalid, wvalid}, 3'b000);
            if (s_aw_done && !s_w_done)
                check_val("aw_dropped_w_held", {awvalid, wvalid}, 2'b01);
            if (s_w_done && !s_aw_done)
                check_val("w_dropped_aw_held", {awvalid, wvalid}, 2'b10);
            if (inflight)
                check_val("no_grant_busy", {i_arready, d_arready, d_awready, d_wready}, 4'b0000);
            if (d_awready || d_wready)
                check_val("aw_w_ready_pair", {d_awready, d_wready}, 2'b11);
            if (s_rd) begin
                check_val("rready_route", rready, (cur_kind == 0) ? i_rready : d_rready);
                check_val("rvalid_route", {i_rvalid, d_rvalid},
                          (cur_kind == 0) ? {rvalid, 1'b0} : {1'b0, rvalid});
            end
            if (s_b)
                check_val("b_route", {d_bvalid, bready}, {bvalid, d_bready});

            n_hs = 0;
            if (i_arvalid && i_arready) begin n_hs++; note_grant(0); end
            if (d_arvalid && d_arready) begin n_hs++; note_grant(1); end
            if (d_awvalid && d_wvalid && d_awready && d_wready) begin n_hs++; note_grant(2); end
            if (n_hs != 0) check_val("single_grant", n_hs, 1);

            if (arvalid && arready) begin
                exp_addr = (cur_kind == 0) ? i_addr : dr_addr;
                check_val("araddress", araddress, exp_addr);
                check_val("arprot", arprot, (cur_kind == 0) ? PROT_INSTR : PROT_DATA);
                s_rd = 1;
                s_rdelay = $urandom_range(0, 3);
                s_rdata = (araddress == 32'h100) ? 32'hDEADBEEF : $urandom;
                s_rresp = 2'($urandom_range(0, 3));
            end
            if (awvalid && awready) begin
                check_val("awaddress", awaddress, dw_addr);
                check_val("awprot", awprot, PROT_DATA);
                s_aw_done = 1;
            end
            if (wvalid && wready) begin
                check_val("wdata", wdata, dw_data);
                check_val("wstrb", wstrb, dw_strb);
                s_w_done = 1;
            end
            if (s_aw_done && s_w_done) begin
                s_aw_done = 0; s_w_done = 0;
                s_b = 1;
                s_bdelay = $urandom_range(0, 3);
                s_bresp = 2'($urandom_range(0, 3));
            end
            if (rvalid && rready) begin
                if (cur_kind == 0)
                    check_val("i_rdata_resp", {i_rvalid, i_rresp, i_rdata}, {1'b1, s_rresp, s_rdata});
                else
                    check_val("d_rdata_resp", {d_rvalid, d_rresp, d_rdata}, {1'b1, s_rresp, s_rdata});
                s_rd = 0;
                inflight = 0;
            end
            if (bvalid && bready) begin
                check_val("d_bresp", {d_bvalid, d_bresp}, {1'b1, s_bresp});
                s_b = 0;
                inflight = 0;
            end
            cyc++;
        end
        if (cyc >= 200) check_val("round_timeout", 1'b1, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int mask;
        reset = 0;
        i_arvalid = 0; i_araddress = '0; i_arprot = '0; i_rready = 0;
        d_arvalid = 0; d_araddress = '0; d_arprot = '0; d_rready = 0;
        d_awvalid = 0; d_awaddress = '0; d_awprot = '0;
        d_wvalid = 0; d_wdata = '0; d_wstrb = '0; d_bready = 0;
        clear_slave();
        model_last = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_arvalid = 1; d_arvalid = 1; d_awvalid = 1; d_wvalid = 1;
        #1;
        check_val("reset_readys", {i_arready, d_arready, d_awready, d_wready}, 4'b0000);
        check_val("reset_valids", {arvalid, awvalid, wvalid, rready, bready, i_rvalid, d_rvalid, d_bvalid}, 8'h00);
        check_val("reset_payload", {araddress, awaddress, arprot, awprot}, 70'h0);
        check_val("reset_wpayload", {wdata, wstrb}, 36'h0);
        @(negedge clk);
        i_arvalid = 0; d_arvalid = 0; d_awvalid = 0; d_wvalid = 0;
        reset = 1;

        run_round(1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0, 4'h0);
        run_round(1, 1, 0, 32'h200, 32'h300, 32'h0, 32'h0, 4'h0);
        run_round(1, 0, 0, 32'h204, 32'h0, 32'h0, 32'h0, 4'h0);
        run_round(1, 1, 0, 32'h208, 32'h308, 32'h0, 32'h0, 4'h0);
        run_round(0, 0, 1, 32'h0, 32'h0, 32'h400, 32'h12345678, 4'b0011);
        run_round(0, 1, 1, 32'h0, 32'h500, 32'h504, 32'hCAFEF00D, 4'b1111);
        for (int r = 0; r < 40; r++) begin
            mask = $urandom_range(1, 7);
            run_round(mask[0], mask[1], mask[2], $urandom, $urandom, $urandom, $urandom,
                      4'($urandom_range(0, 15)));
        end

        // Reset while an I read sits in RDATA.
        @(negedge clk);
        clear_slave();
        i_arvalid = 1; i_araddress = 32'h600; i_arprot = PROT_INSTR; i_rready = 1;
        arready = 1;
        @(negedge clk);
        i_arvalid = 0;
        @(negedge clk);
        #1;
        check_val("pre_reset_rready", rready, 1'b1);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        rvalid = 1;
        #1;
        check_val("mid_reset_valids", {arvalid, awvalid, wvalid, rready, bready, i_rvalid, d_rvalid, d_bvalid}, 8'h00);
        check_val("mid_reset_readys", {i_arready, d_arready, d_awready, d_wready}, 4'b0000);
        @(negedge clk);
        reset = 1;
        clear_slave();
        model_last = 1;
        run_round(1, 0, 0, 32'h700, 32'h0, 32'h0, 32'h0, 4'h0);
        run_round(1, 1, 1, 32'h800, 32'h900, 32'hA00, 32'h55AA55AA, 4'b1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
